// File: rtl/cross_result_serializer.sv
// Captures one three-word cross-product result frame and streams it out
// one word per beat over valid/ready, counting completed frames.
module cross_result_serializer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_vo1,
  input  logic [DATA_W-1:0] in_vo2,
  input  logic [DATA_W-1:0] in_vo3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              idx, idx_nxt;
  logic [2:0][DATA_W-1:0]  r, r_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    in_acc;

  // Final-beat accept lets a new frame load with no idle bubble.
  assign in_ready = !rst && ((state == IDLE) ||
                             (state == SEND && idx == 2'd2 && out_ready));
  assign in_acc   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    r_nxt     = r;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (in_acc) begin
          r_nxt     = {in_vo3, in_vo2, in_vo1};
          idx_nxt   = 2'd0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx != 2'd2) begin
            idx_nxt = idx + 2'd1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
            idx_nxt = 2'd0;
            if (in_acc) r_nxt = {in_vo3, in_vo2, in_vo1};
            else        state_nxt = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 2'd0;
      r     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      r     <= r_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    out_valid = (state == SEND);
    out_idx   = out_valid ? idx : 2'd0;
    out_last  = out_valid && (idx == 2'd2);
    out_data  = '0;
    if (out_valid) begin
      case (idx)
        2'd0:    out_data = r[0];
        2'd1:    out_data = r[1];
        default: out_data = r[2];
      endcase
    end
  end

  assign frame_cnt = cnt;

endmodule

// File: tb/tb_cross_result_serializer.sv
// Directed scenarios plus a randomized run scored against a queue-based
// model of the word stream.
module tb_cross_result_serializer;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  logic              clk = 0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_vo1, in_vo2, in_vo3;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_idx;
  logic              out_last;
  logic [CNT_W-1:0]  frame_cnt;

  int total  = 0;
  int passed = 0;

  cross_result_serializer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vo1(in_vo1), .in_vo2(in_vo2), .in_vo3(in_vo3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1; in_valid = 0; out_ready = 0;
    in_vo1 = 0; in_vo2 = 0; in_vo3 = 0;
    tick();
    rst = 0;
  endtask

  task automatic set_frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    in_vo1 = a; in_vo2 = b; in_vo3 = c;
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 1; out_ready = 1;
    set_frame(16'h1234, 16'h5678, 16'h9abc);
    tick(); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else passed++;
    total++; if (out_data !== 16'h0) $display("FAIL reset_data got %h want 0000", out_data); else passed++;
    total++; if (out_idx !== 2'd0 || out_last !== 1'b0) $display("FAIL reset_idx_last got %0d/%0b want 0/0", out_idx, out_last); else passed++;
    total++; if (frame_cnt !== 8'd0) $display("FAIL reset_cnt got %0d want 0", frame_cnt); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b want 0", in_ready); else passed++;
    rst = 0; in_valid = 0; #1;
    total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %0b want 1", in_ready); else passed++;
    tick();
  endtask

  task automatic test_basic;
    logic [15:0] exp [3];
    exp[0] = 16'h0006; exp[1] = 16'hFFF7; exp[2] = 16'hFFF4;
    do_reset();
    set_frame(16'sd6, -16'sd9, -16'sd12);
    in_valid = 1; out_ready = 1;
    tick(); in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (out_valid !== 1'b1 || out_data !== exp[k]) $display("FAIL basic_word%0d got v=%0b %h want v=1 %h", k, out_valid, out_data, exp[k]); else passed++;
      total++; if (out_idx !== 2'(k) || out_last !== (k == 2)) $display("FAIL basic_idx%0d got %0d/%0b want %0d/%0b", k, out_idx, out_last, k, k == 2); else passed++;
      tick();
    end
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_idle got v=%0b r=%0b want 0/1", out_valid, in_ready); else passed++;
    total++; if (frame_cnt !== 8'd1) $display("FAIL basic_cnt got %0d want 1", frame_cnt); else passed++;
  endtask

  task automatic test_backpressure;
    do_reset();
    set_frame(16'sd6, -16'sd9, -16'sd12);
    in_valid = 1; out_ready = 1;
    tick(); in_valid = 0;
    tick(); out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (out_data !== 16'hFFF7 || out_idx !== 2'd1 || out_valid !== 1'b1) $display("FAIL bp_hold%0d got %h idx %0d want fff7 idx 1", k, out_data, out_idx); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d got %0b want 0", k, in_ready); else passed++;
      tick();
    end
    out_ready = 1;
    tick(); #1;
    total++; if (out_data !== 16'hFFF4 || out_last !== 1'b1) $display("FAIL bp_word2 got %h last %0b want fff4 1", out_data, out_last); else passed++;
    tick(); #1;
    total++; if (frame_cnt !== 8'd1 || out_valid !== 1'b0) $display("FAIL bp_done got cnt %0d v %0b want 1 0", frame_cnt, out_valid); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp [6];
    exp[0] = 16'h0006; exp[1] = 16'hFFF7; exp[2] = 16'hFFF4;
    exp[3] = 16'h7FFF; exp[4] = 16'h8000; exp[5] = 16'h0001;
    do_reset();
    set_frame(16'sd6, -16'sd9, -16'sd12);
    in_valid = 1; out_ready = 1;
    tick();
    set_frame(16'h7FFF, 16'h8000, 16'h0001);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) in_valid = 0;
      #1;
      total++; if (out_valid !== 1'b1 || out_data !== exp[k] || out_idx !== 2'(k % 3)) $display("FAIL b2b_word%0d got v=%0b %h idx %0d want 1 %h %0d", k, out_valid, out_data, out_idx, exp[k], k % 3); else passed++;
      total++; if (in_ready !== (k % 3 == 2)) $display("FAIL b2b_in_ready%0d got %0b want %0b", k, in_ready, k % 3 == 2); else passed++;
      tick();
    end
    #1;
    total++; if (frame_cnt !== 8'd2 || out_valid !== 1'b0) $display("FAIL b2b_done got cnt %0d v %0b want 2 0", frame_cnt, out_valid); else passed++;
  endtask

  task automatic test_mid_reset;
    do_reset();
    set_frame(16'sd6, -16'sd9, -16'sd12);
    in_valid = 1; out_ready = 1;
    tick(); in_valid = 0;
    tick();
    rst = 1; #1;
    total++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready_hi got %0b want 0", in_ready); else passed++;
    tick(); rst = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (out_valid !== 1'b0 || frame_cnt !== 8'd0 || in_ready !== 1'b1) $display("FAIL midrst_idle%0d got v=%0b cnt %0d r=%0b want 0 0 1", k, out_valid, frame_cnt, in_ready); else passed++;
      tick();
    end
  endtask

  task automatic test_ignore_input;
    do_reset();
    set_frame(16'sd6, -16'sd9, -16'sd12);
    in_valid = 1; out_ready = 1;
    tick();
    set_frame(16'h1111, 16'h2222, 16'h3333);
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL ign_in_ready got %0b want 0", in_ready); else passed++;
    tick(); in_valid = 0; #1;
    total++; if (out_data !== 16'hFFF7) $display("FAIL ign_word1 got %h want fff7", out_data); else passed++;
    tick(); #1;
    total++; if (out_data !== 16'hFFF4) $display("FAIL ign_word2 got %h want fff4", out_data); else passed++;
    tick(); #1;
    total++; if (out_valid !== 1'b0 || frame_cnt !== 8'd1) $display("FAIL ign_done got v %0b cnt %0d want 0 1", out_valid, frame_cnt); else passed++;
  endtask

  task automatic test_wrap;
    do_reset();
    set_frame(16'h0a0a, 16'h0b0b, 16'h0c0c);
    in_valid = 1; out_ready = 1;
    tick();
    for (int f = 1; f <= 256; f++) begin
      if (f == 256) in_valid = 0;
      tick(); tick(); tick();
      #1;
      if (f == 255) begin
        total++; if (frame_cnt !== 8'd255) $display("FAIL wrap_255 got %0d want 255", frame_cnt); else passed++;
      end
      if (f == 256) begin
        total++; if (frame_cnt !== 8'd0) $display("FAIL wrap_0 got %0d want 0", frame_cnt); else passed++;
      end
    end
  endtask

  task automatic test_random;
    logic [17:0] q [$];
    logic [17:0] e;
    logic        mready, hold;
    int          mcnt;
    do_reset();
    mcnt = 0; hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        in_valid = ($urandom % 10) < 6;
        in_vo1 = ($urandom % 8 == 0) ? 16'h8000 : 16'($urandom);
        in_vo2 = 16'($urandom);
        in_vo3 = 16'($urandom);
      end
      out_ready = ($urandom % 10) < 7;
      #1;
      mready = (q.size() == 0) || (q.size() == 1 && out_ready);
      total++; if (in_ready !== mready) $display("FAIL rnd_in_ready c%0d got %0b want %0b", c, in_ready, mready); else passed++;
      total++; if (out_valid !== (q.size() > 0)) $display("FAIL rnd_valid c%0d got %0b want %0b", c, out_valid, q.size() > 0); else passed++;
      if (q.size() > 0) begin
        total++; if ({out_idx, out_data} !== q[0] || out_last !== (q[0][17:16] == 2'd2)) $display("FAIL rnd_word c%0d got %0d:%h want %0d:%h", c, out_idx, out_data, q[0][17:16], q[0][15:0]); else passed++;
      end
      total++; if (frame_cnt !== 8'(mcnt)) $display("FAIL rnd_cnt c%0d got %0d want %0d", c, frame_cnt, 8'(mcnt)); else passed++;
      if (q.size() > 0 && out_ready) begin
        e = q.pop_front();
        if (e[17:16] == 2'd2) mcnt++;
      end
      if (in_valid && mready) begin
        q.push_back({2'd0, in_vo1}); q.push_back({2'd1, in_vo2}); q.push_back({2'd2, in_vo3});
      end
      hold = in_valid && !mready;
      tick();
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 0;
    in_vo1 = 0; in_vo2 = 0; in_vo3 = 0;
    tick();
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_ignore_input();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
